// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU, branch and memory completions in per-FU
// FIFOs and broadcasts one per cycle, chosen round-robin, as a registered CDB beat.
module cdb_arbiter #(
    parameter int ROB_W  = 5,
    parameter int PREG_W = 7,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              b_valid,
    input  logic [ROB_W-1:0]  b_rob,
    input  logic [PREG_W-1:0] b_pd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    input  logic              mem_valid,
    input  logic [ROB_W-1:0]  mem_rob,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic [PREG_W-1:0] cdb_pd,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_wen,
    output logic [1:0]        cdb_src
);

    localparam int NFU   = 3;
    localparam int ENT_W = ROB_W + PREG_W + DATA_W;
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    // Handshake: a completion transfers at a rising edge where x_valid and x_ready
    // are both high; x_ready depends only on registered occupancy and flush, never
    // on x_valid, and a refused completion must be held by the FU.

    logic [ENT_W-1:0] q_mem  [NFU][QDEPTH];
    logic [PTR_W-1:0] q_head [NFU];
    logic [PTR_W-1:0] q_tail [NFU];
    logic [CNT_W-1:0] q_cnt  [NFU];

    logic [ENT_W-1:0] in_ent [NFU];
    logic [NFU-1:0]   in_valid;
    logic [NFU-1:0]   rdy;
    logic [NFU-1:0]   push;
    logic [NFU-1:0]   pop;
    logic [3:0]       req;

    logic [1:0]       rr_ptr;
    logic [1:0]       win;
    logic [1:0]       cand;
    logic             any_req;
    logic [ENT_W-1:0] head_ent;

    function automatic logic [1:0] next_fu(input logic [1:0] f);
        return (f == 2'd2) ? 2'd0 : f + 2'd1;
    endfunction

    always_comb begin
        in_valid  = {mem_valid, b_valid, alu_valid};
        in_ent[0] = {alu_rob, alu_pd, alu_data};
        in_ent[1] = {b_rob, b_pd, b_data};
        in_ent[2] = {mem_rob, mem_pd, mem_data};
    end

    always_comb begin
        req = 4'd0;
        rdy = '0;
        for (int f = 0; f < NFU; f++) begin
            req[f] = (q_cnt[f] != '0);
            rdy[f] = (q_cnt[f] < CNT_W'(QDEPTH)) && !flush;
        end
    end

    // Search starts at rr_ptr and wraps ALU->BR->MEM; the first non-empty queue wins.
    always_comb begin
        any_req = 1'b0;
        win     = 2'd0;
        cand    = rr_ptr;
        for (int i = 0; i < NFU; i++) begin
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
            cand = next_fu(cand);
        end
    end

    always_comb begin
        push     = '0;
        pop      = '0;
        head_ent = '0;
        for (int f = 0; f < NFU; f++) begin
            push[f] = in_valid[f] && rdy[f];
            pop[f]  = any_req && !flush && (win == 2'(f));
            if (win == 2'(f)) begin
                head_ent = q_mem[f][q_head[f]];
            end
        end
    end

    assign alu_ready = rdy[0];
    assign b_ready   = rdy[1];
    assign mem_ready = rdy[2];

    always_ff @(posedge clk) begin
        for (int f = 0; f < NFU; f++) begin
            if (push[f]) begin
                q_mem[f][q_tail[f]] <= in_ent[f];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < NFU; f++) begin
                q_head[f] <= '0;
                q_tail[f] <= '0;
                q_cnt[f]  <= '0;
            end
        end else if (flush) begin
            for (int f = 0; f < NFU; f++) begin
                q_head[f] <= '0;
                q_tail[f] <= '0;
                q_cnt[f]  <= '0;
            end
        end else begin
            for (int f = 0; f < NFU; f++) begin
                if (push[f]) begin
                    q_tail[f] <= q_tail[f] + PTR_W'(1);
                end
                if (pop[f]) begin
                    q_head[f] <= q_head[f] + PTR_W'(1);
                end
                case ({push[f], pop[f]})
                    2'b10:   q_cnt[f] <= q_cnt[f] + CNT_W'(1);
                    2'b01:   q_cnt[f] <= q_cnt[f] - CNT_W'(1);
                    default: q_cnt[f] <= q_cnt[f];
                endcase
            end
        end
    end

    // Payload fields keep their last value on idle cycles; only valid/wen drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_wen   <= 1'b0;
            cdb_rob   <= '0;
            cdb_pd    <= '0;
            cdb_data  <= '0;
            cdb_src   <= 2'd0;
            rr_ptr    <= 2'd0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            cdb_wen   <= 1'b0;
            rr_ptr    <= 2'd0;
        end else if (any_req) begin
            cdb_valid <= 1'b1;
            cdb_rob   <= head_ent[ENT_W-1 -: ROB_W];
            cdb_pd    <= head_ent[DATA_W +: PREG_W];
            cdb_data  <= head_ent[DATA_W-1:0];
            cdb_wen   <= (head_ent[DATA_W +: PREG_W] != '0);
            cdb_src   <= win;
            rr_ptr    <= next_fu(win);
        end else begin
            cdb_valid <= 1'b0;
            cdb_wen   <= 1'b0;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares one common data bus (CDB) among the ALU, branch and memory functional units. Each FU completion is buffered in a small per-FU queue, and one completion per cycle is selected by round-robin. The winner is driven as a registered broadcast: ROB done tag, preg wakeup and PRF write data. Sits between the FU outputs and the ROB, reservation stations and phys_reg_file write port. It replaces the three independent fu_*_done / p_*_in / data_*_in paths into ooo_top.

Parameters:
ROB_W, 5, ROB tag width (32-entry ROB)
PREG_W, 7, physical register index width (128 pregs)
DATA_W, 32, result data width
QDEPTH, 2, entries per FU queue (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash; clears all queued and output state
alu_valid / b_valid / mem_valid  in  1 each  FU completion offered this cycle
alu_rob / b_rob / mem_rob  in  ROB_W each  ROB tag of completing instruction
alu_pd / b_pd / mem_pd  in  PREG_W each  destination preg; 0 = no register write
alu_data / b_data / mem_data  in  DATA_W each  result value
alu_ready / b_ready / mem_ready  out  1 each  queue can accept this cycle
cdb_valid  out  1  broadcast valid (one cycle per completion)
cdb_rob  out  ROB_W  ROB tag to mark complete
cdb_pd  out  PREG_W  preg to wake up
cdb_data  out  DATA_W  PRF write data
cdb_wen  out  1  PRF write enable = cdb_valid && cdb_pd != 0
cdb_src  out  2  winning source: 0=ALU, 1=BR, 2=MEM (3 unused)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: all queues empty; rr_ptr=0 (ALU); cdb_valid=0, cdb_wen=0; cdb_rob/pd/data=0; cdb_src=0; all *_ready=1 once reset is released.
- Enqueue: at a rising edge with x_valid && x_ready, {rob, pd, data} is written at the tail of queue x.
- x_valid with x_ready=0 is not accepted. The FU must hold its completion. The block does not track or drop it.
- Ready: x_ready = (count_x < QDEPTH) && !flush. It is computed from the registered count only; a same-cycle pop does not free space (no full pass-through).
- Arbitration (combinational on queue heads): candidates are the non-empty queues. Search order starts at rr_ptr and wraps ALU->BR->MEM->ALU. The first non-empty queue wins.
- Pop: at each rising edge, if any queue is non-empty and flush=0, the winner's head is popped and loaded into the cdb_* registers with cdb_valid=1. rr_ptr then becomes (winner+1) mod 3. Otherwise cdb_valid=0 and rr_ptr is unchanged.
- cdb_* fields hold their last value when cdb_valid=0. Consumers must qualify on cdb_valid.
- Latency: a completion accepted at edge k reaches the queue head at the earliest at edge k. It can be popped at edge k+1 and is visible on the CDB during the cycle after edge k+1. Minimum latency is 2 edges; there is no bypass.
- Simultaneous enqueue and pop on the same queue is legal. Count is unchanged; head advances and tail advances.
- Ordering: FIFO within each FU. No ordering guarantee across FUs.
- Throughput: 1 broadcast per cycle. With all three queues continuously full, each FU gets exactly 1 grant in every 3 cycles.
- Pointers: wrap modulo QDEPTH; count is QDEPTH+1 values wide.
- Flush: at an edge with flush=1, all queues are emptied and cdb_valid is forced to 0. Inputs in that cycle are not accepted (ready=0). rr_ptr resets to 0.
- Reset mid-operation: state clears immediately (asynchronously) to reset values; queued completions are lost.

Test Plan:
1. Reset release, then single ALU completion (rob=3, pd=12, data=0xA500000C) accepted at edge k -> cdb_valid=1 for exactly 1 cycle after edge k+1, with cdb_rob=3, cdb_pd=12, cdb_data=0xA500000C, cdb_wen=1, cdb_src=0.
2. ALU, BR and MEM all valid in the same cycle (rob 1, 2, 3; BR pd=0), rr_ptr=0 -> CDB order rob 1, 2, 3 on three consecutive cycles. cdb_wen=0 for the BR beat; rr_ptr ends at 0.
3. Round-robin fairness: hold all three FUs valid for 12 cycles -> grants follow ALU, BR, MEM repeating; each src gets 4 grants; no src is granted twice in a row while others are non-empty.
4. Backpressure: MEM valid for 4 consecutive cycles while ALU and BR each keep a non-empty queue (QDEPTH=2) -> mem_ready drops to 0 after 2 accepts. The FU holds; all 4 MEM completions appear in order with none lost or duplicated.
5. Flush: 3 entries queued and cdb_valid=1, flush=1 for one cycle -> cdb_valid=0 the next cycle, all *_ready=1, no stale broadcast. A new ALU completion afterwards is granted first (rr_ptr=0).
6. Async reset mid-stream: assert reset between edges with 2 queued entries -> cdb_valid=0 immediately without waiting for a clock edge. After release, no old rob tag ever appears on the CDB.
